// File: rtl/dcache_direct_mapped_if.sv
// CPU-side and memory-side bundles for the direct-mapped data cache.
// master drives requests, slave answers them.
interface dcache_cpu_if;
    logic        p1_req_i;
    logic        p1_write_i;
    logic [31:0] p1_addr_i;
    logic [31:0] p1_data_i;
    logic [31:0] p1_data_o;
    logic        p1_stall_o;

    modport master (
        output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_stall_o
    );
    modport slave (
        input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_stall_o
    );
endinterface

interface dcache_mem_if #(
    parameter int BLOCK_BITS = 256
);
    logic                  mem_enable_o;
    logic                  mem_write_o;
    logic [31:0]           mem_addr_o;
    logic [BLOCK_BITS-1:0] mem_data_o;
    logic [BLOCK_BITS-1:0] mem_data_i;
    logic                  mem_ack_i;

    modport master (
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  mem_data_i, mem_ack_i
    );
    modport slave (
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output mem_data_i, mem_ack_i
    );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back, write-allocate L1 data cache.
// Misses stall the pipeline while whole blocks move over a req/ack bus.
module dcache_direct_mapped #(
    parameter int LINES      = 32,
    parameter int BLOCK_BITS = 256
) (
    input logic          clk_i,
    input logic          rst_i,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(BLOCK_BITS / 8);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int POS_W  = $clog2(BLOCK_BITS);
    localparam int WORD_W = OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILLED} state_t;
    state_t state, state_n;

    logic [LINES-1:0]      valid, dirty;
    logic [TAG_W-1:0]      tags  [LINES];
    logic [BLOCK_BITS-1:0] lines [LINES];

    logic [IDX_W-1:0]      idx, miss_idx, miss_idx_n;
    logic [TAG_W-1:0]      tag, miss_tag, miss_tag_n;
    logic [WORD_W-1:0]     word;
    logic [POS_W-1:0]      pos;
    logic                  hit, miss, ack, fill, store_hit;
    logic                  en, en_n, wr, wr_n;
    logic [31:0]           addr, addr_n;
    logic [BLOCK_BITS-1:0] wdata, wdata_n;
    logic                  unused;

    assign idx    = cpu.p1_addr_i[OFF_W +: IDX_W];
    assign tag    = cpu.p1_addr_i[31 -: TAG_W];
    assign word   = cpu.p1_addr_i[2 +: WORD_W];
    assign pos    = {word, 5'b0};
    assign unused = ^cpu.p1_addr_i[1:0];

    assign hit       = cpu.p1_req_i & valid[idx] & (tags[idx] == tag);
    assign miss      = cpu.p1_req_i & ~hit;
    assign store_hit = (state == IDLE) & hit & cpu.p1_write_i;
    assign ack       = mem.mem_ack_i & en;

    assign cpu.p1_data_o  = hit ? lines[idx][pos +: 32] : '0;
    assign cpu.p1_stall_o = (state != IDLE) | miss;

    assign mem.mem_enable_o = en;
    assign mem.mem_write_o  = wr;
    assign mem.mem_addr_o   = addr;
    assign mem.mem_data_o   = wdata;

    // Bus outputs are registered so they stay flat for the whole request
    // and fall asynchronously with reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            en       <= 1'b0;
            wr       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            miss_idx <= '0;
            miss_tag <= '0;
        end else begin
            state    <= state_n;
            en       <= en_n;
            wr       <= wr_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            miss_idx <= miss_idx_n;
            miss_tag <= miss_tag_n;
        end
    end

    always_comb begin
        state_n    = state;
        en_n       = en;
        wr_n       = wr;
        addr_n     = addr;
        wdata_n    = wdata;
        miss_idx_n = miss_idx;
        miss_tag_n = miss_tag;
        fill       = 1'b0;
        unique case (state)
            IDLE: begin
                if (miss) begin
                    miss_idx_n = idx;
                    miss_tag_n = tag;
                    en_n       = 1'b1;
                    if (valid[idx] & dirty[idx]) begin
                        state_n = WRITEBACK;
                        wr_n    = 1'b1;
                        addr_n  = {tags[idx], idx, {OFF_W{1'b0}}};
                        wdata_n = lines[idx];
                    end else begin
                        state_n = ALLOCATE;
                        wr_n    = 1'b0;
                        addr_n  = {tag, idx, {OFF_W{1'b0}}};
                        wdata_n = '0;
                    end
                end
            end
            WRITEBACK: begin
                if (ack) begin
                    state_n = ALLOCATE;
                    en_n    = 1'b0;
                    wr_n    = 1'b0;
                    addr_n  = '0;
                    wdata_n = '0;
                end
            end
            ALLOCATE: begin
                // Entered with the bus idle after a write-back: one gap cycle.
                if (!en) begin
                    en_n   = 1'b1;
                    wr_n   = 1'b0;
                    addr_n = {miss_tag, miss_idx, {OFF_W{1'b0}}};
                end else if (ack) begin
                    fill    = 1'b1;
                    state_n = REFILLED;
                    en_n    = 1'b0;
                    addr_n  = '0;
                end
            end
            REFILLED: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
        end else if (store_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            lines[miss_idx] <= mem.mem_data_i;
            tags[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            lines[idx][pos +: 32] <= cpu.p1_data_i;
        end
    end
endmodule
